// File: rtl/itrx_aib_phy_pkg.sv
// Shared definitions for the AIB PHY handshake controllers: FSM encoding and
// default parameter values.
package itrx_aib_phy_pkg;

  // 2'd3 is never entered on purpose; the controller treats it as a fault and
  // recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_BAD  = 2'd3
  } hs_state_e;

  localparam int TIMEOUT_DEFAULT = 200;

endpackage

// File: rtl/itrx_aib_phy_bit_sync.sv
// Multi-flop bit synchroniser for a single level signal crossing into clk.
// Output latency is NUM_FLOPS cycles; all flops clear on reset.
module itrx_aib_phy_bit_sync #(
  parameter int NUM_FLOPS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [NUM_FLOPS-1:0] sync_q;

  // NOTE: flops use non-blocking assignments so every stage samples the value
  // its predecessor held before the edge, giving a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_FLOPS-2:0], d};
    end
  end

  assign q = sync_q[NUM_FLOPS-1];

endmodule

// File: rtl/itrx_aib_phy_hs_src_ctl.sv
// Source side of a 4-phase req/ack handshake: captures a word, raises xfer_req,
// waits for the resynchronised ack (with optional timeout) and its release.
module itrx_aib_phy_hs_src_ctl
  import itrx_aib_phy_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int NUM_FLOPS = 2,
  parameter int TO_WIDTH  = 8,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DWIDTH-1:0] load_data,
  output logic              load_ready,
  output logic              xfer_req,
  output logic [DWIDTH-1:0] xfer_data,
  input  logic              xfer_ack_async,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  // Last legal count value; with the timeout disabled the counter simply
  // saturates at all-ones.
  localparam logic [TO_WIDTH-1:0] CNT_LAST =
    (TIMEOUT == 0) ? '1 : TO_WIDTH'(TIMEOUT - 1);

  hs_state_e             state, state_nxt;
  logic [TO_WIDTH-1:0]   cnt, cnt_nxt;
  logic                  acked, acked_nxt;
  logic                  req_nxt, done_nxt, to_nxt;
  logic [DWIDTH-1:0]     data_nxt;
  logic                  ack_s;

  itrx_aib_phy_bit_sync #(
    .NUM_FLOPS (NUM_FLOPS)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (xfer_ack_async),
    .q     (ack_s)
  );

  // A stale ack still high from a previous exchange must clear before a new
  // request may start, otherwise it would be taken as an instant ack.
  assign load_ready = (state == ST_IDLE) && !ack_s;
  assign busy       = (state != ST_IDLE);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acked_nxt = acked;
    req_nxt   = xfer_req;
    data_nxt  = xfer_data;
    done_nxt  = 1'b0;
    to_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (load_valid && load_ready) begin
          data_nxt  = load_data;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          acked_nxt = 1'b0;
          state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        if (cnt != CNT_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end
        // Ack is tested first so it wins over a timeout in the same cycle.
        if (ack_s) begin
          req_nxt   = 1'b0;
          acked_nxt = 1'b1;
          state_nxt = ST_REL;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          req_nxt   = 1'b0;
          to_nxt    = 1'b1;
          acked_nxt = 1'b0;
          state_nxt = ST_REL;
        end
      end

      ST_REL: begin
        // No timeout here: the remote side must always be allowed to finish.
        if (!ack_s) begin
          done_nxt  = acked;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        req_nxt   = 1'b0;
        acked_nxt = 1'b0;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acked       <= 1'b0;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      acked       <= acked_nxt;
      xfer_req    <= req_nxt;
      xfer_data   <= data_nxt;
      done        <= done_nxt;
      timeout_err <= to_nxt;
    end
  end

endmodule

// File: tb/tb_itrx_aib_phy_hs_src_ctl.sv
// Bench for itrx_aib_phy_hs_src_ctl: one instance with TIMEOUT=10, one with the
// timeout disabled, both compared every cycle against a transaction-level model.
module tb_itrx_aib_phy_hs_src_ctl;

  localparam int NF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid [2];
  logic [15:0] load_data  [2];
  logic        load_ready [2];
  logic        xfer_req   [2];
  logic [15:0] xfer_data  [2];
  logic        xfer_ack_async [2];
  logic        busy       [2];
  logic        done       [2];
  logic        timeout_err[2];

  logic        man_ack  [2];
  logic        resp_ack [2];
  logic        resp_en  [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int d = 0; d < 2; d++) xfer_ack_async[d] = man_ack[d] | resp_ack[d];
  end

  itrx_aib_phy_hs_src_ctl #(
    .DWIDTH(16), .NUM_FLOPS(NF), .TO_WIDTH(8), .TIMEOUT(10)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid[0]), .load_data(load_data[0]), .load_ready(load_ready[0]),
    .xfer_req(xfer_req[0]), .xfer_data(xfer_data[0]), .xfer_ack_async(xfer_ack_async[0]),
    .busy(busy[0]), .done(done[0]), .timeout_err(timeout_err[0])
  );

  itrx_aib_phy_hs_src_ctl #(
    .DWIDTH(16), .NUM_FLOPS(NF), .TO_WIDTH(8), .TIMEOUT(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid[1]), .load_data(load_data[1]), .load_ready(load_ready[1]),
    .xfer_req(xfer_req[1]), .xfer_data(xfer_data[1]), .xfer_ack_async(xfer_ack_async[1]),
    .busy(busy[1]), .done(done[1]), .timeout_err(timeout_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tmo(input int d);
    return (d == 0) ? 10 : 0;
  endfunction

  // Transaction-level model: ack history as seen after the synchroniser, and
  // the phase of the current exchange with its elapsed REQ cycles.
  logic [NF-1:0] m_hist [2];
  bit            m_in_req [2], m_in_rel [2], m_acked [2];
  bit            m_req [2], m_done [2], m_to [2];
  logic [15:0]   m_data [2];
  int            m_req_cycles [2];
  bit            m_ack_seen;

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_hist[d] = '0; m_in_req[d] = 0; m_in_rel[d] = 0; m_acked[d] = 0;
        m_req[d] = 0; m_done[d] = 0; m_to[d] = 0; m_data[d] = '0; m_req_cycles[d] = 0;
      end else begin
        m_ack_seen = m_hist[d][NF-1];
        m_hist[d]  = {m_hist[d][NF-2:0], xfer_ack_async[d]};
        m_done[d]  = 0;
        m_to[d]    = 0;
        if (!m_in_req[d] && !m_in_rel[d]) begin
          if (load_valid[d] && !m_ack_seen) begin
            m_data[d] = load_data[d]; m_req[d] = 1; m_in_req[d] = 1;
            m_req_cycles[d] = 0; m_acked[d] = 0;
          end
        end else if (m_in_req[d]) begin
          if (m_ack_seen) begin
            m_req[d] = 0; m_acked[d] = 1; m_in_req[d] = 0; m_in_rel[d] = 1;
          end else begin
            m_req_cycles[d]++;
            if (tmo(d) != 0 && m_req_cycles[d] == tmo(d)) begin
              m_req[d] = 0; m_to[d] = 1; m_in_req[d] = 0; m_in_rel[d] = 1;
            end
          end
        end else if (!m_ack_seen) begin
          m_in_rel[d] = 0;
          m_done[d]   = m_acked[d];
        end
      end
    end
  end

  // Per-scenario observations used by the literal checks.
  int          done_cnt [2], to_cnt [2], req_hi [2];
  int          first_rise [2], last_rise [2];
  logic [15:0] first_done_data [2], last_done_data [2];
  logic        prev_req [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_xfer_req", d),    xfer_req[d],    m_req[d]);
      check($sformatf("d%0d_xfer_data", d),   xfer_data[d],   m_data[d]);
      check($sformatf("d%0d_busy", d),        busy[d],        m_in_req[d] | m_in_rel[d]);
      check($sformatf("d%0d_done", d),        done[d],        m_done[d]);
      check($sformatf("d%0d_timeout_err", d), timeout_err[d], m_to[d]);
      check($sformatf("d%0d_load_ready", d),  load_ready[d],
            !m_in_req[d] && !m_in_rel[d] && !m_hist[d][NF-1]);
      if (done[d] === 1'b1) begin
        if (done_cnt[d] == 0) first_done_data[d] = xfer_data[d];
        last_done_data[d] = xfer_data[d];
        done_cnt[d]++;
      end
      if (timeout_err[d] === 1'b1) to_cnt[d]++;
      if (xfer_req[d] === 1'b1) begin
        req_hi[d]++;
        if (prev_req[d] !== 1'b1) begin
          if (first_rise[d] < 0) first_rise[d] = cyc;
          last_rise[d] = cyc;
        end
      end
      prev_req[d] = xfer_req[d];
    end
  end

  task automatic clr_mon();
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; to_cnt[d] = 0; req_hi[d] = 0;
      first_rise[d] = -1; last_rise[d] = -1;
      first_done_data[d] = '0; last_done_data[d] = '0;
    end
  endtask

  // Remote side: ack 3 cycles after seeing req, release 3 cycles after req falls.
  task automatic responder(input int d);
    forever begin
      @(posedge clk); #2;
      if (resp_en[d] && xfer_req[d] && !resp_ack[d]) begin
        repeat (3) @(posedge clk);
        #2 resp_ack[d] = 1'b1;
        for (int i = 0; i < 100 && xfer_req[d]; i++) begin
          @(posedge clk); #2;
        end
        repeat (3) @(posedge clk);
        #2 resp_ack[d] = 1'b0;
      end
    end
  endtask

  task automatic wait_accept(input int d);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (xfer_req[d]) begin ok = 1; break; end
    end
    check($sformatf("d%0d_wait_accept", d), ok, 1);
  endtask

  task automatic wait_idle(input int d, input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #2;
      if (!busy[d]) begin ok = 1; break; end
    end
    check($sformatf("d%0d_wait_idle", d), ok, 1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic load(input int d, input logic [15:0] w);
    @(posedge clk); #2;
    load_valid[d] = 1'b1;
    load_data[d]  = w;
    wait_accept(d);
    load_valid[d] = 1'b0;
    load_data[d]  = 16'hDEAD;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      load_valid[d] = 0; load_data[d] = '0; man_ack[d] = 0; resp_ack[d] = 0; resp_en[d] = 0;
    end
    clr_mon();
    fork
      responder(0);
      responder(1);
    join_none

    // Reset held with random inputs; the compare process checks outputs.
    repeat (5) begin
      @(posedge clk); #2;
      for (int d = 0; d < 2; d++) begin
        load_valid[d] = 1'($urandom_range(0, 1));
        load_data[d]  = 16'($urandom);
        man_ack[d]    = 1'($urandom_range(0, 1));
      end
    end
    for (int d = 0; d < 2; d++) begin
      load_valid[d] = 0; load_data[d] = '0; man_ack[d] = 0;
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    check("rst_load_ready0", load_ready[0], 1);
    check("rst_load_ready1", load_ready[1], 1);
    check("rst_xfer_data0", xfer_data[0], 16'h0000);

    // Clean transfer.
    clr_mon();
    resp_en[0] = 1;
    load(0, 16'hA5C3);
    wait_idle(0, 100);
    settle();
    check("clean_done_cnt", done_cnt[0], 1);
    check("clean_to_cnt", to_cnt[0], 0);
    check("clean_data", first_done_data[0], 16'hA5C3);
    check("clean_req_cycles", req_hi[0], 6);
    resp_en[0] = 0;

    // Timeout with no ack at all.
    clr_mon();
    load(0, 16'h1234);
    wait_idle(0, 100);
    settle();
    check("to_req_cycles", req_hi[0], 10);
    check("to_to_cnt", to_cnt[0], 1);
    check("to_done_cnt", done_cnt[0], 0);

    // Ack arrives after the timeout and is held; REL must wait for its release.
    clr_mon();
    load(0, 16'h5A5A);
    repeat (8) @(posedge clk);
    #2 man_ack[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2 load_valid[0] = 1'b1; load_data[0] = 16'h7777;
    repeat (9) @(posedge clk);
    #2 man_ack[0] = 1'b0;
    wait_accept(0);
    load_valid[0] = 1'b0;
    wait_idle(0, 100);
    settle();
    check("late_done_cnt", done_cnt[0], 0);
    check("late_to_cnt", to_cnt[0], 2);
    check("late_reaccept_gap", last_rise[0] - first_rise[0], 24);

    // Ack reaches the controller in the very cycle the timeout would fire.
    clr_mon();
    load(0, 16'hC0DE);
    repeat (7) @(posedge clk);
    #2 man_ack[0] = 1'b1;
    repeat (5) @(posedge clk);
    #2 man_ack[0] = 1'b0;
    wait_idle(0, 100);
    settle();
    check("simul_to_cnt", to_cnt[0], 0);
    check("simul_done_cnt", done_cnt[0], 1);
    check("simul_data", first_done_data[0], 16'hC0DE);

    // Back-to-back words with load_valid held and load_data churning while busy.
    clr_mon();
    resp_en[0] = 1;
    @(posedge clk); #2;
    load_valid[0] = 1'b1; load_data[0] = 16'h0001;
    wait_accept(0);
    load_data[0] = 16'hFFFF;
    repeat (4) @(posedge clk);
    #2 load_data[0] = 16'h0002;
    wait_idle(0, 100);
    wait_accept(0);
    load_valid[0] = 1'b0;
    wait_idle(0, 100);
    settle();
    check("b2b_done_cnt", done_cnt[0], 2);
    check("b2b_first_data", first_done_data[0], 16'h0001);
    check("b2b_second_data", last_done_data[0], 16'h0002);
    check("b2b_gap", last_rise[0] - first_rise[0], 13);
    resp_en[0] = 0;

    // Async reset in the middle of REQ.
    clr_mon();
    load(0, 16'h3C3C);
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("midrst_xfer_req", xfer_req[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_xfer_data", xfer_data[0], 16'h0000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    check("midrst_load_ready", load_ready[0], 1);

    // Timeout disabled: ack withheld for 1000 cycles.
    clr_mon();
    load(1, 16'h0F0F);
    repeat (1000) @(posedge clk);
    #2 man_ack[1] = 1'b1;
    for (int i = 0; i < 20 && xfer_req[1]; i++) begin
      @(posedge clk); #2;
    end
    man_ack[1] = 1'b0;
    wait_idle(1, 100);
    settle();
    check("noto_to_cnt", to_cnt[1], 0);
    check("noto_done_cnt", done_cnt[1], 1);
    check("noto_req_cycles", req_hi[1], 1003);
    check("noto_data", first_done_data[1], 16'h0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itrx_aib_phy_hs_src_ctl.md
Name: itrx_aib_phy_hs_src_ctl

Overview:
Source-side controller for a 4-phase req/ack handshake that moves a DWIDTH-bit configuration word into another clock domain of the AIB PHY.
- Captures a word from a valid/ready load interface and holds it stable on xfer_data.
- Sequences xfer_req against a remote ack, which is resynchronised internally with the team's bit synchroniser.
- Reports completion, busy status and an ack timeout to the local control logic.

Parameters:
DWIDTH, 16, width of transferred word
NUM_FLOPS, 2, synchroniser depth on xfer_ack_async (min 2)
TO_WIDTH, 8, timeout counter width
TIMEOUT, 200, cycles allowed in REQ before timeout_err; 0 disables timeout (must be < 2**TO_WIDTH)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
load_valid  input  1  local word offered
load_data  input  DWIDTH  word to transfer
load_ready  output  1  controller can accept a word
xfer_req  output  1  level request to remote domain (registered)
xfer_data  output  DWIDTH  held word (registered), stable while xfer_req=1 or state!=IDLE
xfer_ack_async  input  1  remote ack, asynchronous to clk
busy  output  1  state != IDLE
done  output  1  1-cycle pulse: handshake completed with ack
timeout_err  output  1  1-cycle pulse: ack not seen within TIMEOUT

Behaviour:
- Reset values: xfer_req=0, xfer_data=0, done=0, timeout_err=0, busy=0, load_ready=1 once ack_s=0. State=IDLE, counter=0, acked=0, synchroniser flops=0.
- ack_s is xfer_ack_async through NUM_FLOPS flops, giving NUM_FLOPS cycles of latency.
- load_ready = (state==IDLE) & ~ack_s. This is combinational from registers and never depends on load_valid.
- States:
  - IDLE: on load_valid & load_ready at edge N, xfer_data<=load_data, xfer_req<=1, cnt<=0, acked<=0, go REQ. xfer_req is visible after edge N.
  - REQ: cnt increments each cycle.
    - If ack_s=1: xfer_req<=0, acked<=1, go REL.
    - Else if TIMEOUT!=0 and cnt==TIMEOUT-1: xfer_req<=0, timeout_err<=1 for 1 cycle, acked<=0, go REL.
    - If ack_s=1 and the timeout fire in the same cycle, ack wins and there is no timeout_err.
  - REL: waits for ack_s=0 with no timeout, so the remote side can always finish the protocol. On ack_s=0 go IDLE; done<=1 for 1 cycle only if acked=1.
- Clean transfer latency, load accept to done, is 2*NUM_FLOPS + remote response + 2 cycles.
- Counter saturates and never wraps. Values above TIMEOUT-1 cannot occur.
- load_valid while busy is ignored, and load_data is not sampled.
- Late ack after a timeout: REL still waits for the ack to drop, and done stays 0.
- ack_s=1 while IDLE (stale ack) keeps load_ready=0 until it drops. No state change.
- Async reset mid-transfer immediately drops xfer_req and returns to IDLE. The remote side then sees the request fall and completes its own release.
- done and timeout_err are never asserted in the same cycle.

Decomposition:
- Shared package itrx_aib_phy_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_REQ=2'd1, ST_REL=2'd2 (2'd3 is illegal and recovers to IDLE)
  - TIMEOUT default constant
- One sub-module instance: itrx_aib_phy_bit_sync #(NUM_FLOPS) on xfer_ack_async. No other sub-modules.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0, load_ready=1 after release. Assert rst_n mid-REQ -> xfer_req=0 the same instant.
- Clean transfer: load 16'hA5C3, remote acks 3 cycles after seeing req and drops ack 3 cycles after req falls -> xfer_data=16'hA5C3 held throughout, exactly one done pulse, timeout_err never asserted.
- Timeout: TIMEOUT=10, no ack -> xfer_req drops after exactly 10 cycles in REQ, one timeout_err pulse, return to IDLE after 1 cycle in REL, done=0.
- Late ack after timeout: ack rises at cycle 15 and falls at cycle 20 -> controller stays in REL until ack_s=0, done=0, and a new load is accepted only after that.
- Back-to-back: load_valid held with 2 words (16'h0001, 16'h0002) -> second word accepted only in IDLE with ack_s=0. Both transferred in order, and load_data changes while busy are ignored.
- Simultaneous events: ack_s rises in the exact cycle cnt==TIMEOUT-1 -> no timeout_err, done pulses after release. TIMEOUT=0 with ack withheld for 1000 cycles -> no timeout.
